// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write arbiter.
// Imported by the interface, the arbiter core and the round-robin unit.
package regfile_pkg;

  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);
  localparam int DW   = 32;

  typedef enum logic {
    CLEAR,
    RUN
  } rf_arb_state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Write-back request bundle plus register-file write port.
// master = requesters/register file side, slave = arbiter.
interface regfile_write_arbiter_if;
  import regfile_pkg::*;

  logic          clear_req_i;
  logic          req0_valid_i;
  logic [AW-1:0] req0_addr_i;
  logic [DW-1:0] req0_data_i;
  logic          req0_ready_o;
  logic          req1_valid_i;
  logic [AW-1:0] req1_addr_i;
  logic [DW-1:0] req1_data_i;
  logic          req1_ready_o;
  logic          rf_we_o;
  logic [AW-1:0] rf_addr_o;
  logic [DW-1:0] rf_data_o;
  logic          clear_done_o;

  modport master (
    output clear_req_i,
    output req0_valid_i, req0_addr_i, req0_data_i,
    input  req0_ready_o,
    output req1_valid_i, req1_addr_i, req1_data_i,
    input  req1_ready_o,
    input  rf_we_o, rf_addr_o, rf_data_o,
    input  clear_done_o
  );

  modport slave (
    input  clear_req_i,
    input  req0_valid_i, req0_addr_i, req0_data_i,
    output req0_ready_o,
    input  req1_valid_i, req1_addr_i, req1_data_i,
    output req1_ready_o,
    output rf_we_o, rf_addr_o, rf_data_o,
    output clear_done_o
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant with a single priority pointer.
// The pointer flips to the other requester after every grant.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant: lone requester wins, a tie goes to the pointer.
  always_comb begin
    grant_o = 2'b00;
    ptr_d   = ptr_q;
    if (en_i) begin
      unique case (1'b1)
        (valid_i[0] && (!valid_i[1] || !ptr_q)):
          grant_o = 2'b01;
        (valid_i[1] && (!valid_i[0] || ptr_q)):
          grant_o = 2'b10;
        default:
          grant_o = 2'b00;
      endcase
    end
    if (grant_o[0]) ptr_d = 1'b1;
    if (grant_o[1]) ptr_d = 1'b0;
  end

  // Pointer register; requester 0 has priority out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: zero-sweeps x1..x31, then
// arbitrates two write-back requesters onto a registered port.
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  regfile_write_arbiter_if.slave  bus
);

  rf_arb_state_e state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          we_q, we_d;
  rf_wr_t        wr_q, wr_d;
  rf_wr_t        sel;
  logic          arb_en;
  logic [1:0]    grant;

  // A clear request in RUN steals the cycle from both requesters.
  assign arb_en = (state_q == RUN) && !bus.clear_req_i;

  rr_arbiter2 u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (arb_en),
    .valid_i ({bus.req1_valid_i, bus.req0_valid_i}),
    .grant_o (grant)
  );

  assign bus.req0_ready_o = grant[0];
  assign bus.req1_ready_o = grant[1];
  assign bus.rf_we_o      = we_q;
  assign bus.rf_addr_o    = wr_q.addr;
  assign bus.rf_data_o    = wr_q.data;
  assign bus.clear_done_o = (state_q == RUN);

  // Mux the granted requester's payload.
  always_comb begin
    sel.addr = bus.req0_addr_i;
    sel.data = bus.req0_data_i;
    if (grant[1]) begin
      sel.addr = bus.req1_addr_i;
      sel.data = bus.req1_data_i;
    end
  end

  // Sweep/run sequencing and next write-port contents.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    we_d      = 1'b0;
    wr_d      = wr_q;
    unique case (state_q)
      CLEAR: begin
        we_d      = 1'b1;
        wr_d.addr = clr_idx_q;
        wr_d.data = '0;
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(NREG - 1))
          state_d = RUN;
      end
      RUN: begin
        if (bus.clear_req_i) begin
          state_d   = CLEAR;
          clr_idx_d = AW'(1);
        end else if (|grant) begin
          // x0 writes are accepted but dropped here.
          if (sel.addr != '0) begin
            we_d = 1'b1;
            wr_d = sel;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // State, sweep index and registered write port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      clr_idx_q <= AW'(1);
      we_q      <= 1'b0;
      wr_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      we_q      <= we_d;
      wr_q      <= wr_d;
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Owns the register file's single write port (enable, a3, write data) and shares it between two write-back requesters. Requester 0 is the ALU/single-cycle write-back path; requester 1 is a multi-cycle unit such as load or mul/div.
After every reset, and on explicit request, it sweeps x1..x31 to zero before granting any requester. It sits between the execute/write-back stage and register_file.

Parameters:
- NREG, 32, number of architectural registers; index 0 is hardwired zero.
- AW, 5, register address width, equal to $clog2(NREG).
- DW, 32, data width.

Ports:
- clk_i  in  1  system clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- clear_req_i  in  1  request a zero-sweep of x1..x31; sampled in RUN only.
- req0_valid_i  in  1  requester 0 has a write pending.
- req0_addr_i  in  AW  requester 0 destination register.
- req0_data_i  in  DW  requester 0 write data.
- req0_ready_o  out  1  requester 0 granted this cycle.
- req1_valid_i  in  1  requester 1 has a write pending.
- req1_addr_i  in  AW  requester 1 destination register.
- req1_data_i  in  DW  requester 1 write data.
- req1_ready_o  out  1  requester 1 granted this cycle.
- rf_we_o  out  1  register file write enable; drives reg_write_enable_i.
- rf_addr_o  out  AW  register file write address; drives a3_i.
- rf_data_o  out  DW  register file write data; drives reg_write_data_i.
- clear_done_o  out  1  high while in RUN.

Behaviour:
- Reset (async, any time, including mid-sweep or mid-transfer):
  - rf_we_o=0, rf_addr_o=0, rf_data_o=0, ready outputs=0, clear_done_o=0.
  - FSM enters CLEAR with clr_idx=1; round-robin pointer set to requester 0.
- FSM state CLEAR:
  - Each cycle, register rf_we_o=1, rf_addr_o=clr_idx, rf_data_o=0, then increment clr_idx.
  - After issuing idx NREG-1, go to RUN. The sweep takes exactly NREG-1 = 31 cycles, and the first RUN cycle follows the write to x31.
  - Both ready outputs are 0 throughout; clear_req_i is ignored.
- FSM state RUN:
  - clear_done_o=1.
  - If clear_req_i=1: grant nothing this cycle, go to CLEAR with clr_idx=1. Requests issued that cycle are not accepted.
- Arbitration (RUN, no clear_req_i):
  - One valid requester: it is granted.
  - Both valid: the requester named by the round-robin pointer is granted.
  - After any grant, the pointer moves to the other requester.
  - ready is combinational from valids, pointer and state. Requesters must not make valid depend on ready.
- Handshake:
  - A transfer occurs when valid & ready are both high.
  - A requester must hold valid, addr and data stable until it is granted.
- Write port:
  - Registered, one-cycle latency. A transfer in cycle N gives rf_we_o=1 with its addr/data in cycle N+1, committed by register_file at the end of N+1.
  - A transfer with addr=0 is accepted (ready high), but rf_we_o stays 0 and x0 is never written.
  - In cycles with no transfer, rf_we_o=0 and rf_addr_o/rf_data_o hold their last values.
- Throughput: at most one write per cycle. Back-to-back grants are sustained with no bubble.

Decomposition:
- Shared package regfile_pkg holds:
  - constants NREG, AW, DW;
  - typedef enum {CLEAR, RUN} rf_arb_state_e;
  - typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} rf_wr_t.
- One sub-module, rr_arbiter2: 2-way round-robin grant logic, with the pointer register and update-on-grant. The FSM, clear counter and output register stay in the top module.

Test Plan:
- Reset then idle:
  - Cycles 1..31 show rf_we_o=1, rf_addr_o=1..31, rf_data_o=0.
  - Cycle 32 shows rf_we_o=0 and clear_done_o=1.
  - register_file then reads 0 on every address.
- Single requester in RUN: req0 valid, addr=5, data=32'h01c00f93.
  - req0_ready_o=1 the same cycle.
  - Next cycle: rf_we_o=1, rf_addr_o=5, rf_data_o=32'h01c00f93. Reading a1=5 afterwards returns that value.
- Both valid for 4 cycles (req0 addr=1, data=A; req1 addr=2, data=B):
  - Grants alternate 0,1,0,1, starting with req0 after reset.
  - Write port shows addr 1,2,1,2 with no idle cycle.
- x0 drop: req1 valid, addr=0, data=32'h000f8083.
  - req1_ready_o=1, rf_we_o stays 0 the next cycle, and register 0 still reads 0.
- clear_req_i pulsed in RUN while req0 is valid:
  - No grant that cycle and the sweep restarts at x1.
  - req0 is granted in the first cycle after the 31-cycle sweep completes.
- rst_i asserted asynchronously mid-sweep (clr_idx=10):
  - Outputs go to 0 immediately without waiting for a clock edge.
  - After release, the sweep restarts from x1.
